// File: rtl/ps_redirect_ctrl_pkg.sv
// Shared types and constants for the program-state redirect controller.
// program_state_t mirrors the architectural program-state register layout.
package ps_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2,
    RESUME = 2'd3
  } redirect_state_e;

  localparam logic [1:0] SRC_TRAP   = 2'd0;
  localparam logic [1:0] SRC_IRQ    = 2'd1;
  localparam logic [1:0] SRC_XRET   = 2'd2;
  localparam logic [1:0] SRC_BRANCH = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  priv;
    logic        ie;
  } program_state_t;

endpackage

// File: rtl/ps_redirect_ctrl_if.sv
// Redirect request / program-state write bundle between the commit logic,
// the redirect controller and the program-state register.
interface ps_redirect_ctrl_if
  import ps_redirect_ctrl_pkg::*;
#(
  parameter int N_SRC = 4
) ();

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic           [N_SRC-1:0] i_req;
  program_state_t [N_SRC-1:0] i_req_ps;
  logic           [N_SRC-1:0] o_ack;
  logic                       o_flush;
  logic                       i_drained;
  logic                       o_alter;
  program_state_t             o_ps;
  logic           [IDX_W-1:0] o_cause;
  logic                       o_stall_fetch;
  logic                       o_busy;
  logic                       o_timeout;

  // Requesters, pipeline and program-state register side
  modport master (
    output i_req, i_req_ps, i_drained,
    input  o_ack, o_flush, o_alter, o_ps, o_cause, o_stall_fetch, o_busy, o_timeout
  );

  // Redirect controller side
  modport slave (
    input  i_req, i_req_ps, i_drained,
    output o_ack, o_flush, o_alter, o_ps, o_cause, o_stall_fetch, o_busy, o_timeout
  );

endinterface

// File: rtl/ps_redirect_ctrl_prio_arb.sv
// Combinational fixed-priority arbiter: lowest asserted index wins. With
// bound_en set, only indices strictly below bound may win (preemption check).
module ps_prio_arb #(
  parameter int N_SRC = 4,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic             bound_en,
  input  logic [IDX_W-1:0] bound,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic             valid_s;
  logic [IDX_W-1:0] idx_s;

  // Scan from the top so the lowest eligible index is the last one written
  always_comb begin
    valid_s = 1'b0;
    idx_s   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      logic hit_s;
      hit_s   = req[i] && (!bound_en || (IDX_W'(i) < bound));
      valid_s = hit_s ? 1'b1 : valid_s;
      idx_s   = hit_s ? IDX_W'(i) : idx_s;
    end
  end

  assign valid = valid_s;
  assign idx   = idx_s;

endmodule

// File: rtl/ps_redirect_ctrl.sv
// Redirect controller: arbitrates redirect sources, flushes and drains the
// pipeline, then issues exactly one program-state write per redirect.
module ps_redirect_ctrl
  import ps_redirect_ctrl_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ps_redirect_ctrl_if.slave   bus
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(DRAIN_TIMEOUT - 1);

  redirect_state_e  state_r;
  logic [IDX_W-1:0] idx_r;
  program_state_t   ps_r;
  logic [CNT_W-1:0] cnt_r;

  logic [N_SRC-1:0] ack_r;
  logic             flush_r;
  logic             alter_r;
  program_state_t   ps_out_r;
  logic [IDX_W-1:0] cause_r;
  logic             stall_r;
  logic             busy_r;
  logic             timeout_r;

  logic             arb_valid_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             bound_en_s;
  logic             preempt_s;
  logic [IDX_W-1:0] sel_idx_s;
  program_state_t   sel_ps_s;

  function automatic logic [N_SRC-1:0] onehot_f(input logic [IDX_W-1:0] idx);
    onehot_f      = '0;
    onehot_f[idx] = 1'b1;
  endfunction

  // In DRAIN the arbiter only reports sources that outrank the latched one
  assign bound_en_s = (state_r == DRAIN);

  ps_prio_arb #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req      (bus.i_req),
    .bound_en (bound_en_s),
    .bound    (idx_r),
    .valid    (arb_valid_s),
    .idx      (arb_idx_s)
  );

  // Source and program state that DRAIN carries forward this cycle
  always_comb begin
    preempt_s = bound_en_s && arb_valid_s;
    if (preempt_s) begin
      sel_idx_s = arb_idx_s;
      sel_ps_s  = bus.i_req_ps[arb_idx_s];
    end else begin
      sel_idx_s = idx_r;
      sel_ps_s  = ps_r;
    end
  end

  // Redirect FSM with all outputs registered
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      ps_r      <= '0;
      cnt_r     <= '0;
      ack_r     <= '0;
      flush_r   <= 1'b0;
      alter_r   <= 1'b0;
      ps_out_r  <= '0;
      cause_r   <= '0;
      stall_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      ack_r     <= '0;
      alter_r   <= 1'b0;
      ps_out_r  <= '0;
      cause_r   <= '0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            state_r <= DRAIN;
            idx_r   <= arb_idx_s;
            ps_r    <= bus.i_req_ps[arb_idx_s];
            cnt_r   <= '0;
            ack_r   <= onehot_f(arb_idx_s);
            flush_r <= 1'b1;
            stall_r <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            flush_r <= 1'b0;
            stall_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        DRAIN: begin
          // Counter keeps running across preemption so the timeout bound holds
          cnt_r   <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
          idx_r   <= sel_idx_s;
          ps_r    <= sel_ps_s;
          ack_r   <= preempt_s ? onehot_f(sel_idx_s) : '0;
          flush_r <= 1'b1;
          stall_r <= 1'b1;
          busy_r  <= 1'b1;
          if (bus.i_drained) begin
            state_r  <= COMMIT;
            alter_r  <= 1'b1;
            ps_out_r <= sel_ps_s;
            cause_r  <= sel_idx_s;
          end else if (cnt_r == CNT_TMO) begin
            state_r   <= COMMIT;
            alter_r   <= 1'b1;
            ps_out_r  <= sel_ps_s;
            cause_r   <= sel_idx_s;
            timeout_r <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        COMMIT: begin
          state_r <= RESUME;
          flush_r <= 1'b0;
          stall_r <= 1'b1;
          busy_r  <= 1'b1;
        end
        RESUME: begin
          state_r <= IDLE;
          flush_r <= 1'b0;
          stall_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          flush_r <= 1'b0;
          stall_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ack         = ack_r;
  assign bus.o_flush       = flush_r;
  assign bus.o_alter       = alter_r;
  assign bus.o_ps          = ps_out_r;
  assign bus.o_cause       = cause_r;
  assign bus.o_stall_fetch = stall_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_timeout     = timeout_r;

endmodule

// File: tb/tb_ps_redirect_ctrl.sv
// Directed self-checking bench for ps_redirect_ctrl (DRAIN_TIMEOUT=8).
module tb_ps_redirect_ctrl;
  import ps_redirect_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ps_redirect_ctrl_if #(.N_SRC(4)) bus ();

  ps_redirect_ctrl #(
    .N_SRC         (4),
    .DRAIN_TIMEOUT (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ack"},     64'(bus.o_ack), 64'd0);
    check_eq({tag, "_flush"},   64'(bus.o_flush), 64'd0);
    check_eq({tag, "_alter"},   64'(bus.o_alter), 64'd0);
    check_eq({tag, "_ps"},      64'(bus.o_ps), 64'd0);
    check_eq({tag, "_cause"},   64'(bus.o_cause), 64'd0);
    check_eq({tag, "_stall"},   64'(bus.o_stall_fetch), 64'd0);
    check_eq({tag, "_busy"},    64'(bus.o_busy), 64'd0);
    check_eq({tag, "_timeout"}, 64'(bus.o_timeout), 64'd0);
  endtask

  program_state_t ps_a, ps_b, ps_c, ps_d, ps_e, ps_f, ps_g, ps_h;

  initial begin
    n_checks = 0;
    n_errors = 0;
    ps_a = '{pc: 32'h0000_1000, priv: 2'd3, ie: 1'b0};
    ps_b = '{pc: 32'h0000_2004, priv: 2'd1, ie: 1'b1};
    ps_c = '{pc: 32'h0000_3008, priv: 2'd0, ie: 1'b1};
    ps_d = '{pc: 32'h8000_0000, priv: 2'd3, ie: 1'b0};
    ps_e = '{pc: 32'hDEAD_BEE0, priv: 2'd2, ie: 1'b1};
    ps_f = '{pc: 32'h1234_5678, priv: 2'd1, ie: 1'b0};
    ps_g = '{pc: 32'h0000_4000, priv: 2'd0, ie: 1'b0};
    ps_h = '{pc: 32'h0000_5000, priv: 2'd3, ie: 1'b1};

    rst_n         = 1'b0;
    bus.i_req     = 4'b0000;
    bus.i_req_ps  = '0;
    bus.i_drained = 1'b0;
    @(negedge clk);
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Single request on the lowest-priority source
    bus.i_drained = 1'b1;
    bus.i_req     = 4'b1000;
    bus.i_req_ps[SRC_BRANCH] = ps_a;
    step();
    check_eq("single_ack",   64'(bus.o_ack), 64'b1000);
    check_eq("single_flush", 64'(bus.o_flush), 64'd1);
    check_eq("single_busy",  64'(bus.o_busy), 64'd1);
    check_eq("single_noalt", 64'(bus.o_alter), 64'd0);
    bus.i_req    = 4'b0000;
    bus.i_req_ps = '0;
    step();
    check_eq("single_alter", 64'(bus.o_alter), 64'd1);
    check_eq("single_ps",    64'(bus.o_ps), 64'(ps_a));
    check_eq("single_cause", 64'(bus.o_cause), 64'd3);
    check_eq("single_tmo",   64'(bus.o_timeout), 64'd0);
    check_eq("single_ackcl", 64'(bus.o_ack), 64'd0);
    step();
    check_eq("resume_alter", 64'(bus.o_alter), 64'd0);
    check_eq("resume_stall", 64'(bus.o_stall_fetch), 64'd1);
    check_eq("resume_flush", 64'(bus.o_flush), 64'd0);
    check_eq("resume_busy",  64'(bus.o_busy), 64'd1);
    step();
    check_idle_outputs("single_idle");

    // Simultaneous requests: src1 outranks src3
    bus.i_req = 4'b1010;
    bus.i_req_ps[SRC_IRQ]    = ps_b;
    bus.i_req_ps[SRC_BRANCH] = ps_c;
    step();
    check_eq("simul_ack", 64'(bus.o_ack), 64'b0010);
    bus.i_req = 4'b0000;
    step();
    check_eq("simul_alter", 64'(bus.o_alter), 64'd1);
    check_eq("simul_ps",    64'(bus.o_ps), 64'(ps_b));
    check_eq("simul_cause", 64'(bus.o_cause), 64'd1);
    step();
    step();

    // Preemption of src3 by src0 while draining
    bus.i_drained = 1'b0;
    bus.i_req = 4'b1000;
    bus.i_req_ps[SRC_BRANCH] = ps_a;
    step();
    check_eq("pre_ack3", 64'(bus.o_ack), 64'b1000);
    bus.i_req = 4'b0000;
    step();
    step();
    check_eq("pre_flush", 64'(bus.o_flush), 64'd1);
    bus.i_req = 4'b0001;
    bus.i_req_ps[SRC_TRAP] = ps_d;
    step();
    check_eq("pre_ack0",   64'(bus.o_ack), 64'b0001);
    check_eq("pre_noalt0", 64'(bus.o_alter), 64'd0);
    bus.i_req = 4'b0000;
    bus.i_req_ps = '0;
    step();
    check_eq("pre_noalt1", 64'(bus.o_alter), 64'd0);
    check_eq("pre_ackcl",  64'(bus.o_ack), 64'd0);
    bus.i_drained = 1'b1;
    step();
    check_eq("pre_alter", 64'(bus.o_alter), 64'd1);
    check_eq("pre_ps",    64'(bus.o_ps), 64'(ps_d));
    check_eq("pre_cause", 64'(bus.o_cause), 64'd0);
    step();
    check_eq("pre_once0", 64'(bus.o_alter), 64'd0);
    step();
    check_eq("pre_once1", 64'(bus.o_alter), 64'd0);

    // Forced commit after 8 DRAIN cycles
    bus.i_drained = 1'b0;
    bus.i_req = 4'b0100;
    bus.i_req_ps[SRC_XRET] = ps_e;
    step();
    check_eq("tmo_ack", 64'(bus.o_ack), 64'b0100);
    bus.i_req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("tmo_flush%0d", i), 64'(bus.o_flush), 64'd1);
      check_eq($sformatf("tmo_noalt%0d", i), 64'(bus.o_alter), 64'd0);
      step();
    end
    check_eq("tmo_alter", 64'(bus.o_alter), 64'd1);
    check_eq("tmo_flag",  64'(bus.o_timeout), 64'd1);
    check_eq("tmo_ps",    64'(bus.o_ps), 64'(ps_e));
    check_eq("tmo_cause", 64'(bus.o_cause), 64'd2);
    step();
    check_eq("tmo_clear", 64'(bus.o_timeout), 64'd0);
    step();

    // Reset in the middle of DRAIN abandons the redirect
    bus.i_req = 4'b0001;
    bus.i_req_ps[SRC_TRAP] = ps_f;
    step();
    check_eq("rst_ack", 64'(bus.o_ack), 64'b0001);
    bus.i_req = 4'b0000;
    step();
    rst_n = 1'b0;
    step();
    check_idle_outputs("rst_mid");
    rst_n = 1'b1;
    bus.i_drained = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("rst_noalt%0d", i), 64'(bus.o_alter), 64'd0);
      check_eq($sformatf("rst_nobusy%0d", i), 64'(bus.o_busy), 64'd0);
    end

    // Back-to-back: src2 held through RESUME is re-accepted from IDLE
    bus.i_req = 4'b0100;
    bus.i_req_ps[SRC_XRET] = ps_g;
    step();
    check_eq("b2b_ack1", 64'(bus.o_ack), 64'b0100);
    step();
    check_eq("b2b_alter1", 64'(bus.o_alter), 64'd1);
    check_eq("b2b_ps1",    64'(bus.o_ps), 64'(ps_g));
    step();
    check_eq("b2b_res_ack",   64'(bus.o_ack), 64'd0);
    check_eq("b2b_res_stall", 64'(bus.o_stall_fetch), 64'd1);
    step();
    check_eq("b2b_idle_busy", 64'(bus.o_busy), 64'd0);
    check_eq("b2b_idle_ack",  64'(bus.o_ack), 64'd0);
    bus.i_req_ps[SRC_XRET] = ps_h;
    step();
    check_eq("b2b_ack2", 64'(bus.o_ack), 64'b0100);
    bus.i_req = 4'b0000;
    step();
    check_eq("b2b_alter2", 64'(bus.o_alter), 64'd1);
    check_eq("b2b_ps2",    64'(bus.o_ps), 64'(ps_h));
    check_eq("b2b_cause2", 64'(bus.o_cause), 64'd2);
    step();
    step();
    check_eq("b2b_end_busy", 64'(bus.o_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
